// File: rtl/fcm_pkg.sv
// Shared definitions for the frequency-counter Wishbone master.
// Sequencer states, counter register map and CTRL bit layout.
package fcm_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_RST,
        S_WR_ARM,
        S_GAP,
        S_RD_CTRL,
        S_RD_COUNT,
        S_RD_PHASE,
        S_WR_CLR,
        S_WR_ABORT,
        S_DONE
    } state_t;

    localparam logic [31:0] CTRL_OFS  = 32'd8;
    localparam logic [31:0] COUNT_OFS = 32'd9;
    localparam logic [31:0] PHASE_OFS = 32'd10;

    localparam int ARM_BIT  = 7;
    localparam int DONE_BIT = 6;
    localparam int RST_BIT  = 0;

    localparam logic [31:0] CTRL_RST = 32'd1 << RST_BIT;
    localparam logic [31:0] CTRL_ARM = 32'd1 << ARM_BIT;
    localparam logic [31:0] CTRL_CLR = 32'd0;

endpackage

// File: rtl/fcm_wb_xfer.sv
// Single classic Wishbone transfer engine with stale-ack filtering.
// Optional ack watchdog enabled by macro FCM_ACK_TIMEOUT_EN.
module fcm_wb_xfer
    import fcm_pkg::*;
#(
    parameter logic [7:0] ACK_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdat,
    output logic [31:0] rdat,
    output logic        ok,
    output logic        fail,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic        err_i
);

    logic first;
    logic tmo;

`ifdef FCM_ACK_TIMEOUT_EN
    logic [7:0] wd;

    // Watchdog: holds 1 while idle, counts strobe cycles while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= 8'd1;
        end else if (!cyc_o) begin
            wd <= 8'd1;
        end else if (wd != 8'hFF) begin
            wd <= wd + 8'd1;
        end
    end

    assign tmo = (wd == ACK_TIMEOUT);
`else
    logic [7:0] unused_tmo;
    assign unused_tmo = ACK_TIMEOUT;
    assign tmo = 1'b0;
`endif

    // Launch on req, skip the first strobe cycle, finish on err/ack/timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            adr_o <= '0;
            dat_o <= '0;
            we_o  <= 1'b0;
            sel_o <= '0;
            first <= 1'b0;
            rdat  <= '0;
            ok    <= 1'b0;
            fail  <= 1'b0;
        end else begin
            ok   <= 1'b0;
            fail <= 1'b0;
            if (!cyc_o) begin
                if (req) begin
                    cyc_o <= 1'b1;
                    stb_o <= 1'b1;
                    adr_o <= adr;
                    dat_o <= we ? wdat : '0;
                    we_o  <= we;
                    sel_o <= 4'hF;
                    first <= 1'b1;
                end
            end else if ((!first && (err_i || ack_i)) || tmo) begin
                cyc_o <= 1'b0;
                stb_o <= 1'b0;
                adr_o <= '0;
                dat_o <= '0;
                we_o  <= 1'b0;
                sel_o <= '0;
                first <= 1'b0;
                if (!first && !err_i && ack_i) begin
                    ok   <= 1'b1;
                    rdat <= dat_i;
                end else begin
                    fail <= 1'b1;
                end
            end else begin
                first <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/freq_counter_wb_master.sv
// Sequencer for one frequency-counter measurement over Wishbone.
// Ack watchdog in the transfer engine is enabled by FCM_ACK_TIMEOUT_EN.
module freq_counter_wb_master
    import fcm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [15:0] POLL_GAP    = 16'd16,
    parameter logic [15:0] MAX_POLLS   = 16'd65535,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd255
) (
    input  logic        clk_i,
    input  logic        ext_rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] count_o,
    output logic [31:0] phase_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic        err_i
);

    state_t      state;
    logic        req;
    logic        x_we;
    logic [31:0] x_adr;
    logic [31:0] x_wdat;
    logic [31:0] rdat;
    logic        ok;
    logic        fail;
    logic [15:0] gap_cnt;
    logic [15:0] poll_cnt;
    logic [15:0] poll_nxt;
    logic [31:0] count_sh;
    logic [31:0] phase_sh;

    assign poll_nxt = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;

    fcm_wb_xfer #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_xfer (
        .clk   (clk_i),
        .rst_n (ext_rst_i),
        .req   (req),
        .we    (x_we),
        .adr   (x_adr),
        .wdat  (x_wdat),
        .rdat  (rdat),
        .ok    (ok),
        .fail  (fail),
        .adr_o (adr_o),
        .dat_o (dat_o),
        .dat_i (dat_i),
        .we_o  (we_o),
        .sel_o (sel_o),
        .cyc_o (cyc_o),
        .stb_o (stb_o),
        .ack_i (ack_i),
        .err_i (err_i)
    );

    // Measurement sequencer with registered results and status pulses
    always_ff @(posedge clk_i or negedge ext_rst_i) begin
        if (!ext_rst_i) begin
            state    <= S_IDLE;
            req      <= 1'b0;
            x_we     <= 1'b0;
            x_adr    <= '0;
            x_wdat   <= '0;
            gap_cnt  <= '0;
            poll_cnt <= '0;
            count_sh <= '0;
            phase_sh <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            error_o  <= 1'b0;
            count_o  <= '0;
            phase_o  <= '0;
        end else begin
            req     <= 1'b0;
            done_o  <= 1'b0;
            error_o <= 1'b0;
            if (fail) begin
                state   <= S_DONE;
                busy_o  <= 1'b0;
                error_o <= 1'b1;
            end else begin
                unique case (state)
                    S_IDLE: if (start_i) begin
                        state    <= S_WR_RST;
                        busy_o   <= 1'b1;
                        poll_cnt <= '0;
                        req      <= 1'b1;
                        x_we     <= 1'b1;
                        x_adr    <= BASE_ADDR + CTRL_OFS;
                        x_wdat   <= CTRL_RST;
                    end
                    S_WR_RST: if (ok) begin
                        state  <= S_WR_ARM;
                        req    <= 1'b1;
                        x_we   <= 1'b1;
                        x_adr  <= BASE_ADDR + CTRL_OFS;
                        x_wdat <= CTRL_ARM;
                    end
                    S_WR_ARM: if (ok) begin
                        state   <= S_GAP;
                        gap_cnt <= POLL_GAP;
                    end
                    S_GAP: begin
                        if (gap_cnt <= 16'd1) begin
                            state  <= S_RD_CTRL;
                            req    <= 1'b1;
                            x_we   <= 1'b0;
                            x_adr  <= BASE_ADDR + CTRL_OFS;
                            x_wdat <= '0;
                        end else begin
                            gap_cnt <= gap_cnt - 16'd1;
                        end
                    end
                    S_RD_CTRL: if (ok) begin
                        if (rdat[DONE_BIT]) begin
                            state <= S_RD_COUNT;
                            req   <= 1'b1;
                            x_we  <= 1'b0;
                            x_adr <= BASE_ADDR + COUNT_OFS;
                        end else begin
                            poll_cnt <= poll_nxt;
                            if (poll_nxt >= MAX_POLLS) begin
                                state  <= S_WR_ABORT;
                                req    <= 1'b1;
                                x_we   <= 1'b1;
                                x_adr  <= BASE_ADDR + CTRL_OFS;
                                x_wdat <= CTRL_RST;
                            end else begin
                                state   <= S_GAP;
                                gap_cnt <= POLL_GAP;
                            end
                        end
                    end
                    S_RD_COUNT: if (ok) begin
                        count_sh <= rdat;
                        state    <= S_RD_PHASE;
                        req      <= 1'b1;
                        x_we     <= 1'b0;
                        x_adr    <= BASE_ADDR + PHASE_OFS;
                    end
                    S_RD_PHASE: if (ok) begin
                        phase_sh <= rdat;
                        state    <= S_WR_CLR;
                        req      <= 1'b1;
                        x_we     <= 1'b1;
                        x_adr    <= BASE_ADDR + CTRL_OFS;
                        x_wdat   <= CTRL_CLR;
                    end
                    S_WR_CLR: if (ok) begin
                        state   <= S_DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        count_o <= count_sh;
                        phase_o <= phase_sh;
                    end
                    S_WR_ABORT: if (ok) begin
                        state   <= S_DONE;
                        busy_o  <= 1'b0;
                        error_o <= 1'b1;
                    end
                    S_DONE: state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_freq_counter_wb_master.sv
// Directed bench for freq_counter_wb_master with a small counter target model.
// Covers normal, sticky-ack, bus error, poll limit, async reset and silent target.
module tb_freq_counter_wb_master;

    localparam logic [31:0] BASE   = 32'h100;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;
    localparam logic [31:0] A_CNT  = BASE + 32'd9;
    localparam logic [31:0] A_PH   = BASE + 32'd10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error, we, cyc, stb;
    logic [31:0] count, phase, adr, dat_o, dat_i;
    logic [3:0]  sel;
    logic        ack = 1'b0;
    logic        err = 1'b0;

    int total = 0;
    int bad = 0;

    logic        sticky = 1'b0;
    logic        silent = 1'b0;
    logic        err_cnt = 1'b0;
    int          done_after = 3;
    int          ctrl_base = 0;
    logic [31:0] count_val = 32'd0;
    logic [31:0] phase_val = 32'd0;

    int          ctrl_rd = 0;
    int          log_n = 0;
    int          cur_len = 0;
    logic        stb_q = 1'b0;
    logic        log_we [128];
    logic [31:0] log_adr [128];
    logic [31:0] log_dat [128];
    int          len_log [128];

    freq_counter_wb_master #(
        .BASE_ADDR  (BASE),
        .POLL_GAP   (16'd2),
        .MAX_POLLS  (16'd4),
        .ACK_TIMEOUT(8'd10)
    ) dut (
        .clk_i    (clk),
        .ext_rst_i(rst_n),
        .start_i  (start),
        .busy_o   (busy),
        .done_o   (done),
        .error_o  (error),
        .count_o  (count),
        .phase_o  (phase),
        .adr_o    (adr),
        .dat_o    (dat_o),
        .dat_i    (dat_i),
        .we_o     (we),
        .sel_o    (sel),
        .cyc_o    (cyc),
        .stb_o    (stb),
        .ack_i    (ack),
        .err_i    (err)
    );

    always #5 clk = ~clk;

    // Target read data: CTRL reports done after done_after polls
    always_comb begin
        dat_i = 32'd0;
        if (adr == A_CTRL)
            dat_i = ((ctrl_rd - ctrl_base) > done_after) ? 32'hC0 : 32'h80;
        else if (adr == A_CNT)
            dat_i = count_val;
        else if (adr == A_PH)
            dat_i = phase_val;
    end

    // Target handshake: registered ack/err, or sticky/silent modes
    always @(posedge clk) begin
        if (sticky) begin
            ack <= 1'b1;
            err <= 1'b0;
        end else if (silent || !cyc || !stb || ack || err) begin
            ack <= 1'b0;
            err <= 1'b0;
        end else if (err_cnt && adr == A_CNT) begin
            err <= 1'b1;
        end else begin
            ack <= 1'b1;
        end
    end

    // Bus monitor: log each transfer and its strobe length
    always @(posedge clk) begin
        stb_q <= stb;
        if (stb && !stb_q) begin
            log_we[log_n % 128]  <= we;
            log_adr[log_n % 128] <= adr;
            log_dat[log_n % 128] <= dat_o;
            log_n   <= log_n + 1;
            cur_len <= 1;
            if (!we && adr == A_CTRL)
                ctrl_rd <= ctrl_rd + 1;
        end else if (stb) begin
            cur_len <= cur_len + 1;
        end else if (stb_q) begin
            len_log[(log_n - 1) % 128] <= cur_len;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_xfer(input int i, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        check($sformatf("x%0d_we", i), 32'(log_we[i % 128]), 32'(w));
        check($sformatf("x%0d_adr", i), log_adr[i % 128], a);
        if (w)
            check($sformatf("x%0d_dat", i), log_dat[i % 128], d);
    endtask

    task automatic chk_normal(input int b);
        int mn;
        check("n_xfer", log_n - b, 9);
        chk_xfer(b + 0, 1'b1, A_CTRL, 32'h01);
        chk_xfer(b + 1, 1'b1, A_CTRL, 32'h80);
        for (int k = 2; k < 6; k++)
            chk_xfer(b + k, 1'b0, A_CTRL, 32'h0);
        chk_xfer(b + 6, 1'b0, A_CNT, 32'h0);
        chk_xfer(b + 7, 1'b0, A_PH, 32'h0);
        chk_xfer(b + 8, 1'b1, A_CTRL, 32'h00);
        mn = 99;
        for (int k = 0; k < 9; k++)
            if (len_log[(b + k) % 128] < mn)
                mn = len_log[(b + k) % 128];
        check("min_stb_len_ge2", 32'(mn >= 2), 32'd1);
    endtask

    // Start, then watch a fixed window; restart attempts mid-run and at the end pulse
    task automatic run_op(input int cycles, output int n_done,
                          output int n_err, output int b);
        n_done = 0;
        n_err  = 0;
        b      = log_n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            start = (i == 10);
            if (done) begin
                n_done++;
                check("busy_at_done", 32'(busy), 32'd0);
                start = 1'b1;
            end
            if (error) begin
                n_err++;
                check("bus_at_err", 32'({busy, cyc, stb}), 32'd0);
                start = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int nd, ne, b;
        bit found;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ctl", 32'({busy, done, error, cyc, stb, we, sel}), 32'd0);
        check("rst_count", count, 32'd0);
        check("rst_phase", phase, 32'd0);
        check("rst_adr", adr, 32'd0);
        check("rst_dat", dat_o, 32'd0);

        // normal measurement
        ctrl_base = ctrl_rd;
        done_after = 3;
        count_val = 32'd100000;
        phase_val = 32'h123;
        run_op(200, nd, ne, b);
        check("t1_done", nd, 1);
        check("t1_err", ne, 0);
        check("t1_count", count, 32'd100000);
        check("t1_phase", phase, 32'h123);
        check("t1_busy", 32'(busy), 32'd0);
        chk_normal(b);

        // sticky ack target
        sticky = 1'b1;
        ctrl_base = ctrl_rd;
        count_val = 32'd777;
        phase_val = 32'h2A5;
        run_op(200, nd, ne, b);
        sticky = 1'b0;
        check("t2_done", nd, 1);
        check("t2_err", ne, 0);
        check("t2_count", count, 32'd777);
        check("t2_phase", phase, 32'h2A5);
        chk_normal(b);

        // bus error on COUNT read
        err_cnt = 1'b1;
        ctrl_base = ctrl_rd;
        count_val = 32'd555;
        run_op(200, nd, ne, b);
        err_cnt = 1'b0;
        check("t3_err", ne, 1);
        check("t3_done", nd, 0);
        check("t3_count", count, 32'd777);
        check("t3_phase", phase, 32'h2A5);
        check("t3_busy", 32'(busy), 32'd0);
        check("t3_n_xfer", log_n - b, 7);
        chk_xfer(b + 6, 1'b0, A_CNT, 32'h0);
        check("t3_err_len", len_log[(b + 6) % 128], 2);

        // poll limit reached
        ctrl_base = ctrl_rd;
        done_after = 1000;
        run_op(200, nd, ne, b);
        done_after = 3;
        check("t4_err", ne, 1);
        check("t4_done", nd, 0);
        check("t4_n_xfer", log_n - b, 7);
        for (int k = 2; k < 6; k++)
            chk_xfer(b + k, 1'b0, A_CTRL, 32'h0);
        chk_xfer(b + 6, 1'b1, A_CTRL, 32'h01);
        check("t4_count", count, 32'd777);

        // async reset during a CTRL poll
        ctrl_base = ctrl_rd;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (stb && !we && adr == A_CTRL)
                found = 1'b1;
        end
        check("t5_reach_rd_ctrl", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_cyc_stb", 32'({cyc, stb}), 32'd0);
        check("t5_ctl", 32'({busy, done, error, we, sel}), 32'd0);
        check("t5_count", count, 32'd0);
        check("t5_phase", phase, 32'd0);
        check("t5_adr", adr, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        ctrl_base = ctrl_rd;
        count_val = 32'd4242;
        phase_val = 32'h3E1;
        run_op(200, nd, ne, b);
        check("t5_done", nd, 1);
        check("t5_err", ne, 0);
        check("t5_count2", count, 32'd4242);
        check("t5_phase2", phase, 32'h3E1);
        chk_normal(b);

        // silent target
        silent = 1'b1;
        run_op(300, nd, ne, b);
`ifdef FCM_ACK_TIMEOUT_EN
        check("t6_err", ne, 1);
        check("t6_n_xfer", log_n - b, 1);
        check("t6_len", len_log[b % 128], 10);
`else
        check("t6_err", ne, 0);
        check("t6_bus_held", 32'({busy, cyc, stb}), 32'h7);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        silent = 1'b0;
        #1;
        check("t6_rst_bus", 32'({cyc, stb, busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
